// File: rtl/rx_udp_ring_pkg.sv
// rx_udp_ring shared definitions: byte width, CSR offsets, STATUS bit
// positions and the write-side FSM encoding.
package rx_udp_ring_pkg;

   localparam int OCT = 8;

   localparam logic [31:0] CSR_STATUS  = 32'h000;
   localparam logic [31:0] CSR_HEADLEN = 32'h004;
   localparam logic [31:0] CSR_RELEASE = 32'h008;
   localparam logic [31:0] CSR_DROPS   = 32'h00C;
   localparam logic [31:0] CSR_TSTAMP  = 32'h010;

   localparam int ST_EMPTY_BIT = 8;
   localparam int ST_FULL_BIT  = 9;
   localparam int ST_TRUNC_BIT = 10;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2,
      DROP   = 2'd3
   } wr_state_t;

endpackage

// File: rtl/rx_udp_ring_if.sv
// Wishbone classic slave bus for the RX payload ring.
interface rx_udp_ring_if;
   logic        wbs_stb_i;
   logic        wbs_cyc_i;
   logic        wbs_we_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/rx_udp_ring_ram.sv
// 1W1R synchronous byte RAM holding all ring slots, addressed {slot, offset},
// one cycle read latency.
module rx_udp_ring_ram
   import rx_udp_ring_pkg::*;
#(
   parameter int AW = 13
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  logic [OCT-1:0] wdata,
   input  logic [AW-1:0]  raddr,
   output logic [OCT-1:0] rdata
);

   logic [OCT-1:0] mem [2**AW];

   // Payload write port and registered read port.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/rx_udp_ring.sv
// rx_udp_ring: multi-slot RX payload ring between rx_udp and the Wishbone
// interface. Optional build macro RX_RING_TSTAMP_EN adds a free-running cycle
// counter latched per slot at burst start, readable at CSR 0x010.
module rx_udp_ring
   import rx_udp_ring_pkg::*;
#(
   parameter int          SLOTS      = 4,
   parameter int          SLOT_BYTES = 2048,
   parameter logic [31:0] BASE       = 32'h4000_0000,
   parameter logic [31:0] DATA_OFS   = 32'h0000_1000
) (
   input  logic           wb_clk_i,
   input  logic           rst_n,
   input  logic           rx_data_v,
   input  logic [OCT-1:0] rx_data,
   input  logic           rx_err,
   rx_udp_ring_if.slave   wb,
   output logic           rx_irq
);

   localparam int OFS_W = $clog2(SLOT_BYTES);
   localparam int PTR_W = $clog2(SLOTS);
   localparam int CNT_W = PTR_W + 1;
   localparam int LEN_W = OFS_W + 1;
   localparam int AW    = PTR_W + OFS_W;

   wr_state_t        state;
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count, count_nxt;
   logic [LEN_W-1:0] wcnt;
   logic             trunc_cur;
   logic [LEN_W-1:0] len_q   [SLOTS];
   logic             trunc_q [SLOTS];
   logic [15:0]      drop_cnt;
   logic             ack_q, ram_sel_q;
   logic [31:0]      csr_q, rd_mux;
   logic [OCT-1:0]   ram_rdata;

   logic        full, empty, head_trunc;
   logic        start, fill_wr, ram_we, commit, drop_inc;
   logic        wb_req, rel_wr, drops_wr, data_hit;
   logic [31:0] off, data_rel;
   logic        unused_dat;

   assign full       = (count == CNT_W'(SLOTS));
   assign empty      = (count == '0);
   assign head_trunc = !empty && trunc_q[rd_ptr];

   // A burst is only accepted when a slot is free and its first byte is clean.
   assign start    = (state == IDLE) && rx_data_v && !full && !rx_err;
   assign fill_wr  = (state == FILL) && rx_data_v && !rx_err && (wcnt < LEN_W'(SLOT_BYTES));
   assign ram_we   = start || fill_wr;
   assign commit   = (state == COMMIT);
   assign drop_inc = rx_data_v && (((state == IDLE) && (full || rx_err)) ||
                                   ((state == FILL) && rx_err));

   assign off      = wb.wbs_adr_i - BASE;
   assign data_rel = off - DATA_OFS;
   assign data_hit = (off >= DATA_OFS) && (data_rel < DATA_OFS);
   assign wb_req   = wb.wbs_stb_i && wb.wbs_cyc_i && !ack_q;
   assign rel_wr   = wb_req && wb.wbs_we_i && (off == CSR_RELEASE) && !empty;
   assign drops_wr = wb_req && wb.wbs_we_i && (off == CSR_DROPS);

   // Write data content is irrelevant: RELEASE and DROPS react to the access itself.
   assign unused_dat = ^wb.wbs_dat_i;

   rx_udp_ring_ram #(.AW(AW)) u_ram (
      .clk   (wb_clk_i),
      .we    (ram_we),
      .waddr ({wr_ptr, (start ? OFS_W'(0) : wcnt[OFS_W-1:0])}),
      .wdata (rx_data),
      .raddr ({rd_ptr, data_rel[OFS_W-1:0]}),
      .rdata (ram_rdata)
   );

   // Next occupancy: commit and release in the same cycle cancel out.
   always_comb begin
      count_nxt = count;
      if (commit && !rel_wr)
         count_nxt = count + CNT_W'(1);
      else if (!commit && rel_wr)
         count_nxt = count - CNT_W'(1);
   end

   // Write-side FSM: fill the slot at wr_ptr, commit on burst end, drop on error/full.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         wcnt      <= '0;
         trunc_cur <= 1'b0;
      end else begin
         case (state)
            IDLE: if (rx_data_v) begin
               if (full || rx_err) begin
                  state <= DROP;
               end else begin
                  state     <= FILL;
                  wcnt      <= LEN_W'(1);
                  trunc_cur <= 1'b0;
               end
            end
            FILL: if (!rx_data_v)
               state <= COMMIT;
            else if (rx_err)
               state <= DROP;
            else if (wcnt < LEN_W'(SLOT_BYTES))
               wcnt <= wcnt + LEN_W'(1);
            else
               trunc_cur <= 1'b1;
            COMMIT: begin
               state  <= IDLE;
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            DROP: if (!rx_data_v)
               state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Per-slot length and truncation flag, captured at commit.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SLOTS; i++) begin
            len_q[i]   <= '0;
            trunc_q[i] <= 1'b0;
         end
      end else if (commit) begin
         len_q[wr_ptr]   <= wcnt;
         trunc_q[wr_ptr] <= trunc_cur;
      end
   end

   // Ring occupancy, read pointer and level interrupt tracking the new count.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         count  <= '0;
         rd_ptr <= '0;
         rx_irq <= 1'b0;
      end else begin
         count  <= count_nxt;
         rx_irq <= (count_nxt != '0);
         if (rel_wr)
            rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   // Saturating dropped-burst counter; a software write clears it.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n)
         drop_cnt <= '0;
      else if (drops_wr)
         drop_cnt <= '0;
      else if (drop_inc && (drop_cnt != 16'hFFFF))
         drop_cnt <= drop_cnt + 16'd1;
   end

`ifdef RX_RING_TSTAMP_EN
   logic [31:0] cyc_cnt;
   logic [31:0] tstamp_q [SLOTS];

   // Free-running cycle counter, sampled into the slot being opened.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         cyc_cnt <= '0;
         for (int i = 0; i < SLOTS; i++)
            tstamp_q[i] <= '0;
      end else begin
         cyc_cnt <= cyc_cnt + 32'd1;
         if (start)
            tstamp_q[wr_ptr] <= cyc_cnt;
      end
   end
`endif

   // CSR read multiplexer; anything unmapped reads as zero.
   always_comb begin
      rd_mux = '0;
      case (off)
         CSR_STATUS: begin
            rd_mux[4:0]          = 5'(count);
            rd_mux[ST_EMPTY_BIT] = empty;
            rd_mux[ST_FULL_BIT]  = full;
            rd_mux[ST_TRUNC_BIT] = head_trunc;
         end
         CSR_HEADLEN: rd_mux = empty ? 32'd0 : 32'(len_q[rd_ptr]);
         CSR_DROPS:   rd_mux = {16'd0, drop_cnt};
`ifdef RX_RING_TSTAMP_EN
         CSR_TSTAMP:  rd_mux = empty ? 32'd0 : tstamp_q[rd_ptr];
`endif
         default:     rd_mux = '0;
      endcase
   end

   // Single-cycle ack one clock after the request; RAM data arrives with the ack.
   always_ff @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         ack_q     <= 1'b0;
         ram_sel_q <= 1'b0;
         csr_q     <= '0;
      end else begin
         ack_q     <= wb_req;
         ram_sel_q <= wb_req && !wb.wbs_we_i && data_hit;
         csr_q     <= (wb_req && !wb.wbs_we_i) ? rd_mux : '0;
      end
   end

   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = ram_sel_q ? {24'd0, ram_rdata} : csr_q;

endmodule

// File: tb/tb_rx_udp_ring.sv
// Directed bench for rx_udp_ring: bursts in, Wishbone reads checked through
// an expected-value queue.
module tb_rx_udp_ring;

   localparam int          SLOTS      = 4;
   localparam int          SLOT_BYTES = 2048;
   localparam logic [31:0] BASE       = 32'h4000_0000;
   localparam logic [31:0] DOFS       = 32'h0000_1000;

   logic       wb_clk_i  = 1'b0;
   logic       rst_n     = 1'b0;
   logic       rx_data_v = 1'b0;
   logic [7:0] rx_data   = 8'h00;
   logic       rx_err    = 1'b0;
   logic       rx_irq;

   rx_udp_ring_if wb ();

   rx_udp_ring #(
      .SLOTS(SLOTS), .SLOT_BYTES(SLOT_BYTES), .BASE(BASE), .DATA_OFS(DOFS)
   ) dut (
      .wb_clk_i  (wb_clk_i),
      .rst_n     (rst_n),
      .rx_data_v (rx_data_v),
      .rx_data   (rx_data),
      .rx_err    (rx_err),
      .wb        (wb.slave),
      .rx_irq    (rx_irq)
   );

   always #5 wb_clk_i = ~wb_clk_i;

   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] exp_q [$];
   string       tag_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
   endtask

   task automatic wb_go(input logic we, input logic [31:0] adr, output logic [31:0] rd,
                        output bit ok);
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = we;
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = 32'hA5A5_0001;
      ok = 1'b0;
      rd = '0;
      for (int i = 0; i < 8; i++) begin
         @(posedge wb_clk_i); #1;
         if (wb.wbs_ack_o === 1'b1) begin
            ok = 1'b1;
            rd = wb.wbs_dat_o;
            break;
         end
      end
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
   endtask

   task automatic wb_read(input string tag, input logic [31:0] ofs, input logic [31:0] expv);
      logic [31:0] rd, e;
      bit          ok;
      string       t;
      @(posedge wb_clk_i); #1;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      wb_go(1'b0, BASE + ofs, rd, ok);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      if (!ok) check({t, "_ack_timeout"}, 32'd0, 32'd1);
      else     check(t, rd, e);
   endtask

   task automatic wb_write(input string tag, input logic [31:0] ofs);
      logic [31:0] rd;
      bit          ok;
      @(posedge wb_clk_i); #1;
      wb_go(1'b1, BASE + ofs, rd, ok);
      if (!ok) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
   endtask

   // Drives one burst; optionally issues a RELEASE timed to hit the COMMIT cycle.
   task automatic send_burst(input int len, input logic [7:0] first, input int err_at,
                             input bit rel);
      logic [31:0] rd;
      bit          ok;
      @(posedge wb_clk_i); #1;
      for (int i = 0; i < len; i++) begin
         rx_data_v = 1'b1;
         rx_data   = first + 8'(i);
         rx_err    = (i == err_at);
         @(posedge wb_clk_i); #1;
      end
      rx_data_v = 1'b0;
      rx_err    = 1'b0;
      rx_data   = 8'h00;
      if (rel) begin
         @(posedge wb_clk_i); #1;
         wb_go(1'b1, BASE + 32'h008, rd, ok);
         if (!ok) check("rel_at_commit_ack_timeout", 32'd0, 32'd1);
      end
      repeat (3) @(posedge wb_clk_i);
   endtask

   initial begin
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;

      // Reset state
      repeat (3) @(posedge wb_clk_i);
      #1;
      check("rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
      check("rst_dat", wb.wbs_dat_o, 32'd0);
      check("rst_irq", {31'd0, rx_irq}, 32'd0);
      rst_n = 1'b1;
      wb_read("rst_status", 32'h000, 32'h0000_0100);

      // Reset in the middle of a fill
      @(posedge wb_clk_i); #1;
      for (int i = 0; i < 5; i++) begin
         rx_data_v = 1'b1;
         rx_data   = 8'(i);
         @(posedge wb_clk_i); #1;
      end
      rst_n     = 1'b0;
      rx_data_v = 1'b0;
      repeat (2) @(posedge wb_clk_i);
      #1;
      rst_n = 1'b1;
      repeat (4) @(posedge wb_clk_i);
      #1;
      check("midfill_irq", {31'd0, rx_irq}, 32'd0);
      wb_read("midfill_status", 32'h000, 32'h0000_0100);

      // 64-byte burst
      send_burst(64, 8'h00, -1, 1'b0);
      #1;
      check("b64_irq", {31'd0, rx_irq}, 32'd1);
      wb_read("b64_status", 32'h000, 32'h0000_0001);
      @(posedge wb_clk_i); #1;
      check("ack_single_cycle", {31'd0, wb.wbs_ack_o}, 32'd0);
      wb_read("b64_headlen", 32'h004, 32'd64);
      wb_read("b64_byte5", DOFS + 32'd5, 32'h05);
      wb_read("b64_byte63", DOFS + 32'd63, 32'h3F);
      wb_read("b64_wrap5", DOFS + 32'(SLOT_BYTES) + 32'd5, 32'h05);
      wb_read("unmapped_rd", 32'h020, 32'h0);
`ifndef RX_RING_TSTAMP_EN
      wb_read("tstamp_absent", 32'h010, 32'h0);
`endif
      wb_write("unmapped_wr", 32'h020);
      wb_read("after_unmapped_wr", 32'h000, 32'h0000_0001);
      wb_write("b64_release", 32'h008);
      #1;
      check("b64_rel_irq", {31'd0, rx_irq}, 32'd0);
      wb_read("b64_rel_status", 32'h000, 32'h0000_0100);

      // Five bursts into four slots
      for (int k = 0; k < 5; k++)
         send_burst(10 + k, 8'(16 * k), -1, 1'b0);
      wb_read("full_status", 32'h000, 32'h0000_0204);
      wb_read("full_drops", 32'h00C, 32'd1);
      for (int k = 0; k < 4; k++) begin
         wb_read($sformatf("ring_len%0d", k), 32'h004, 32'(10 + k));
         wb_read($sformatf("ring_b0_%0d", k), DOFS, 32'(16 * k));
         wb_write("ring_release", 32'h008);
      end
      #1;
      check("ring_empty_irq", {31'd0, rx_irq}, 32'd0);
      wb_read("ring_empty_status", 32'h000, 32'h0000_0100);
      wb_read("ring_empty_headlen", 32'h004, 32'd0);
      wb_write("drops_clear", 32'h00C);
      wb_read("drops_cleared", 32'h00C, 32'd0);
      wb_write("release_empty", 32'h008);
      wb_read("release_empty_status", 32'h000, 32'h0000_0100);

      // Oversized burst then a normal one
      send_burst(SLOT_BYTES + 10, 8'h00, -1, 1'b0);
      send_burst(20, 8'hA0, -1, 1'b0);
      wb_read("trunc_status", 32'h000, 32'h0000_0402);
      wb_read("trunc_headlen", 32'h004, 32'(SLOT_BYTES));
      wb_read("trunc_last", DOFS + 32'(SLOT_BYTES - 1), 32'hFF);
      wb_write("trunc_release", 32'h008);
      wb_read("next_status", 32'h000, 32'h0000_0001);
      wb_read("next_headlen", 32'h004, 32'd20);
      wb_read("next_b0", DOFS, 32'hA0);
      wb_read("next_b19", DOFS + 32'd19, 32'hB3);
      wb_write("next_release", 32'h008);

      // Error on byte 10 aborts the burst
      send_burst(30, 8'h20, 10, 1'b0);
      wb_read("err_status", 32'h000, 32'h0000_0100);
      wb_read("err_drops", 32'h00C, 32'd1);
      send_burst(16, 8'h50, -1, 1'b0);
      wb_read("after_err_status", 32'h000, 32'h0000_0001);
      wb_read("after_err_headlen", 32'h004, 32'd16);
      wb_read("after_err_b15", DOFS + 32'd15, 32'h5F);

      // Commit and release in the same cycle
      send_burst(8, 8'h70, -1, 1'b0);
      wb_read("cr_pre_status", 32'h000, 32'h0000_0002);
      send_burst(5, 8'hC0, -1, 1'b1);
      wb_read("cr_status", 32'h000, 32'h0000_0002);
      wb_read("cr_headlen", 32'h004, 32'd8);
      wb_read("cr_b0", DOFS, 32'h70);
      wb_write("cr_release1", 32'h008);
      wb_read("cr_headlen2", 32'h004, 32'd5);
      wb_read("cr_b4", DOFS + 32'd4, 32'hC4);
      wb_write("cr_release2", 32'h008);
      #1;
      check("cr_final_irq", {31'd0, rx_irq}, 32'd0);
      wb_read("cr_final_status", 32'h000, 32'h0000_0100);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
